// File: rtl/multi_channel_tick_pwm_pkg.sv
// Shared constants, types and helpers for the multi-channel tick/PWM generator.
// Channel configuration fields are CFG_MAX_W wide so one struct serves every CNT_W up to 32.
package multi_channel_tick_pwm_pkg;

   localparam int unsigned DEF_BASE_TICK_HZ = 1000;
   localparam int unsigned DEF_RST_PERIOD   = 1000;
   localparam int unsigned DEF_RST_DUTY     = 500;
   localparam int unsigned CFG_MAX_W        = 32;

   typedef struct packed {
      logic [CFG_MAX_W-1:0] period;
      logic [CFG_MAX_W-1:0] duty;
   } ch_cfg_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      int unsigned v;
      result = 0;
      v      = (value > 0) ? value - 1 : 0;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/multi_channel_tick_pwm_channel.sv
// One tick/PWM channel: counter, active and shadow configuration, pending flag,
// wrap decode and registered PWM output. Shadow values reach the active set only at a wrap or while idle.
module multi_channel_tick_pwm_channel
   import multi_channel_tick_pwm_pkg::*;
#(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned RST_PERIOD = DEF_RST_PERIOD,
   parameter int unsigned RST_DUTY   = DEF_RST_DUTY
) (
   input  logic             clk_100MHz,
   input  logic             reset,
   input  logic             base_tick,
   input  logic             en,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_period,
   input  logic [CNT_W-1:0] wr_duty,
   output logic             tick,
   output logic             pwm,
   output logic             pending
);

   ch_cfg_t              active_q;
   ch_cfg_t              shadow_q;
   logic                 pending_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 pwm_p1;
   logic [CFG_MAX_W-1:0] cnt_ext;
   logic                 period_nz;
   logic                 at_wrap;
   logic                 do_apply;

   // Idle channels (disabled or period 0) pick up a pending shadow immediately.
   always_comb begin
      cnt_ext   = CFG_MAX_W'(cnt_q);
      period_nz = (active_q.period != '0);
      at_wrap   = (cnt_ext == active_q.period - CFG_MAX_W'(1));
      tick      = base_tick & en & period_nz & at_wrap;
      do_apply  = pending_q & (tick | ~en | ~period_nz);
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         active_q  <= '{period: CFG_MAX_W'(RST_PERIOD), duty: CFG_MAX_W'(RST_DUTY)};
         shadow_q  <= '0;
         pending_q <= 1'b0;
         cnt_q     <= '0;
         pwm_p1    <= 1'b0;
      end else begin
         if (do_apply)
            active_q <= shadow_q;
         if (wr) begin
            shadow_q.period <= CFG_MAX_W'(wr_period);
            shadow_q.duty   <= CFG_MAX_W'(wr_duty);
         end
         // A write coinciding with an apply keeps the flag set for the newer values.
         if (wr)
            pending_q <= 1'b1;
         else if (do_apply)
            pending_q <= 1'b0;
         if (!en || do_apply || tick)
            cnt_q <= '0;
         else if (base_tick && period_nz)
            cnt_q <= cnt_q + 1'b1;
         // Stage p1: PWM lags the counter by one cycle.
         pwm_p1 <= en & period_nz & (cnt_ext < active_q.duty);
      end
   end

   assign pwm     = pwm_p1;
   assign pending = pending_q;

endmodule

// File: rtl/multi_channel_tick_pwm.sv
// Shared base-tick prescaler feeding NUM_CH independently programmable tick/PWM channels.
// Configuration writes are routed to one channel's shadow by cfg_ch; out-of-range indices are dropped.
module multi_channel_tick_pwm
   import multi_channel_tick_pwm_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
   parameter int unsigned BASE_TICK_HZ = DEF_BASE_TICK_HZ,
   parameter int unsigned NUM_CH       = 2,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned RST_PERIOD   = DEF_RST_PERIOD,
   parameter int unsigned RST_DUTY     = DEF_RST_DUTY
) (
   input  logic              clk_100MHz,
   input  logic              reset,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              cfg_wr,
   input  logic [2:0]        cfg_ch,
   input  logic [CNT_W-1:0]  cfg_period,
   input  logic [CNT_W-1:0]  cfg_duty,
   output logic              base_tick,
   output logic [NUM_CH-1:0] ch_tick,
   output logic [NUM_CH-1:0] pwm,
   output logic [NUM_CH-1:0] cfg_pending
);

   localparam int unsigned PRESC   = CLK_FREQ_HZ / BASE_TICK_HZ;
   localparam int unsigned PRESC_W = (clog2(PRESC) < 1) ? 1 : clog2(PRESC);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);

   logic [PRESC_W-1:0] presc_q;
   logic [NUM_CH-1:0]  wr_sel;

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset)
         presc_q <= '0;
      else if (presc_q == PRESC_LAST)
         presc_q <= '0;
      else
         presc_q <= presc_q + 1'b1;
   end

   // Decoded straight from the register, so it is low throughout reset.
   assign base_tick = (presc_q == PRESC_LAST);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign wr_sel[g] = cfg_wr & (cfg_ch == 3'(g));

      multi_channel_tick_pwm_channel #(
         .CNT_W      (CNT_W),
         .RST_PERIOD (RST_PERIOD),
         .RST_DUTY   (RST_DUTY)
      ) u_channel (
         .clk_100MHz (clk_100MHz),
         .reset      (reset),
         .base_tick  (base_tick),
         .en         (ch_en[g]),
         .wr         (wr_sel[g]),
         .wr_period  (cfg_period),
         .wr_duty    (cfg_duty),
         .tick       (ch_tick[g]),
         .pwm        (pwm[g]),
         .pending    (cfg_pending[g])
      );
   end

endmodule

// File: tb/tb_multi_channel_tick_pwm.sv
// Directed bench for multi_channel_tick_pwm with PRESC=10, two channels, reset period 4 / duty 1.
// Cycle 0 is the first cycle after reset release; windows count events per cycle range.
module tb_multi_channel_tick_pwm;

   logic        clk_100MHz;
   logic        reset;
   logic [1:0]  ch_en;
   logic        cfg_wr;
   logic [2:0]  cfg_ch;
   logic [15:0] cfg_period;
   logic [15:0] cfg_duty;
   logic        base_tick;
   logic [1:0]  ch_tick;
   logic [1:0]  pwm;
   logic [1:0]  cfg_pending;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   int n_base, n_tick0, n_tick1, n_pwm0, n_pwm1, n_pend0, n_pend1;
   int first_base, first_tick0, first_tick1;

   multi_channel_tick_pwm #(
      .CLK_FREQ_HZ  (1000),
      .BASE_TICK_HZ (100),
      .NUM_CH       (2),
      .CNT_W        (16),
      .RST_PERIOD   (4),
      .RST_DUTY     (1)
   ) dut (
      .clk_100MHz  (clk_100MHz),
      .reset       (reset),
      .ch_en       (ch_en),
      .cfg_wr      (cfg_wr),
      .cfg_ch      (cfg_ch),
      .cfg_period  (cfg_period),
      .cfg_duty    (cfg_duty),
      .base_tick   (base_tick),
      .ch_tick     (ch_tick),
      .pwm         (pwm),
      .cfg_pending (cfg_pending)
   );

   initial clk_100MHz = 1'b0;
   always #5 clk_100MHz = ~clk_100MHz;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, $signed(obs), $signed(exp), cyc);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_100MHz);
      #1;
      cyc++;
   endtask

   task automatic release_reset(input logic [1:0] en);
      @(posedge clk_100MHz);
      #1;
      reset = 1'b0;
      ch_en = en;
      cyc   = 0;
   endtask

   task automatic write_cfg(input logic [2:0] ch, input logic [15:0] p, input logic [15:0] d);
      cfg_wr     = 1'b1;
      cfg_ch     = ch;
      cfg_period = p;
      cfg_duty   = d;
      next_cycle();
      cfg_wr     = 1'b0;
   endtask

   // Samples n consecutive cycles starting at the current one.
   task automatic run(input int n);
      n_base = 0; n_tick0 = 0; n_tick1 = 0; n_pwm0 = 0; n_pwm1 = 0; n_pend0 = 0; n_pend1 = 0;
      first_base = -1; first_tick0 = -1; first_tick1 = -1;
      for (int k = 0; k < n; k++) begin
         if (base_tick === 1'b1) begin
            n_base++;
            if (first_base < 0) first_base = cyc;
         end
         if (ch_tick[0] === 1'b1) begin
            n_tick0++;
            if (first_tick0 < 0) first_tick0 = cyc;
         end
         if (ch_tick[1] === 1'b1) begin
            n_tick1++;
            if (first_tick1 < 0) first_tick1 = cyc;
         end
         if (pwm[0] === 1'b1)         n_pwm0++;
         if (pwm[1] === 1'b1)         n_pwm1++;
         if (cfg_pending[0] === 1'b1) n_pend0++;
         if (cfg_pending[1] === 1'b1) n_pend1++;
         next_cycle();
      end
   endtask

   initial begin
      reset      = 1'b1;
      ch_en      = 2'b00;
      cfg_wr     = 1'b0;
      cfg_ch     = 3'd0;
      cfg_period = 16'd0;
      cfg_duty   = 16'd0;
      repeat (3) @(posedge clk_100MHz);
      #1;
      check("rst_base_tick", base_tick, 0);
      check("rst_ch_tick", ch_tick, 0);
      check("rst_pwm", pwm, 0);
      check("rst_pending", cfg_pending, 0);

      // 1: reset configuration, channel 0 only
      release_reset(2'b01);
      run(80);
      check("t1_first_base", first_base, 9);
      check("t1_n_base", n_base, 8);
      check("t1_first_tick0", first_tick0, 39);
      check("t1_n_tick0", n_tick0, 2);
      check("t1_n_pwm0", n_pwm0, 20);
      check("t1_ch1_quiet", n_tick1 + n_pwm1 + n_pend1, 0);

      // 2: mid-period rewrite of channel 0 to period 2 / duty 2
      run(5);
      write_cfg(3'd0, 16'd2, 16'd2);
      check("t2_pending_set", cfg_pending[0], 1);
      run(34);
      check("t2_old_pend", n_pend0, 34);
      check("t2_old_pwm", n_pwm0, 5);
      check("t2_old_tick", first_tick0, 119);
      check("t2_pending_clr", cfg_pending[0], 0);
      run(80);
      check("t2_new_first_tick", first_tick0, 139);
      check("t2_new_n_tick", n_tick0, 4);
      check("t2_new_pwm_high", n_pwm0, 79);
      check("t2_new_pend", n_pend0, 0);

      // 3: write disabled channel 1, then enable it
      write_cfg(3'd1, 16'd3, 16'd0);
      check("t3_pend_one_cycle", cfg_pending[1], 1);
      next_cycle();
      check("t3_pend_clr", cfg_pending[1], 0);
      ch_en = 2'b11;
      run(88);
      check("t3_first_tick1", first_tick1, 229);
      check("t3_n_tick1", n_tick1, 3);
      check("t3_pwm1_low", n_pwm1, 0);
      check("t3_pend1", n_pend1, 0);
      check("t3_n_tick0", n_tick0, 4);
      check("t3_pwm0_high", n_pwm0, 88);

      // 4: out-of-range channel index
      write_cfg(3'd5, 16'd7, 16'd7);
      check("t4_pending", cfg_pending, 0);
      run(60);
      check("t4_n_tick0", n_tick0, 3);
      check("t4_first_tick0", first_tick0, 299);
      check("t4_n_tick1", n_tick1, 2);
      check("t4_first_tick1", first_tick1, 319);
      check("t4_pwm", n_pwm0 * 100 + n_pwm1, 6000);
      check("t4_pend", n_pend0 + n_pend1, 0);

      // 5: write landing exactly on channel 0's wrap
      write_cfg(3'd0, 16'd4, 16'd1);
      run(7);
      check("t5_pre_pend", n_pend0, 7);
      check("t5_pre_pwm", n_pwm0, 7);
      check("t5_wrap_tick", ch_tick[0], 1);
      write_cfg(3'd0, 16'd1, 16'd1);
      run(40);
      check("t5_mid_pend", n_pend0, 40);
      check("t5_mid_tick", first_tick0, 399);
      check("t5_mid_n_tick", n_tick0, 1);
      check("t5_mid_pwm", n_pwm0, 11);
      check("t5_pend_clr", cfg_pending[0], 0);
      run(20);
      check("t5_last_first_tick", first_tick0, 409);
      check("t5_last_n_tick", n_tick0, 2);
      check("t5_last_pwm", n_pwm0, 19);

      // 6: asynchronous reset with a pending write
      write_cfg(3'd1, 16'd5, 16'd5);
      run(4);
      check("t6_pre_pend", cfg_pending[1], 1);
      check("t6_pre_pwm", pwm[0], 1);
      reset = 1'b1;
      #1;
      check("t6_async_pwm", pwm, 0);
      check("t6_async_pend", cfg_pending, 0);
      check("t6_async_tick", ch_tick, 0);
      check("t6_async_base", base_tick, 0);
      repeat (2) @(posedge clk_100MHz);
      release_reset(2'b01);
      run(40);
      check("t6_first_base", first_base, 9);
      check("t6_first_tick0", first_tick0, 39);
      check("t6_n_tick0", n_tick0, 1);
      check("t6_pwm0", n_pwm0, 10);
      check("t6_pend", n_pend0 + n_pend1, 0);
      check("t6_ch1_quiet", n_tick1 + n_pwm1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multi_channel_tick_pwm.md
Name: multi_channel_tick_pwm

Overview:
Parametrised successor to the fixed 1 kHz / 1 Hz / 50 % LED timing block. A shared prescaler derives a base tick from the system clock. NUM_CH independent channels each run a runtime-programmable period and duty, producing a one-cycle tick and a PWM output. Reconfiguration goes through shadow registers, so period and duty changes take effect only at the period boundary and never glitch. Sits between the 100 MHz clock domain and the display, LED and sampling logic of the level meter.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency.
BASE_TICK_HZ, 1000, base tick rate. PRESC = CLK_FREQ_HZ/BASE_TICK_HZ, must be an integer >= 2.
NUM_CH, 2, number of channels, 1..8.
CNT_W, 16, width of period, duty and channel counter.
RST_PERIOD, 1000, active period of every channel after reset, in base ticks.
RST_DUTY, 500, active duty of every channel after reset, in base ticks.

Ports:
clk_100MHz  in  1  system clock; all logic on the rising edge.
reset  in  1  asynchronous, active-high.
ch_en  in  NUM_CH  per-channel run enable.
cfg_wr  in  1  single-cycle configuration write strobe.
cfg_ch  in  3  target channel index.
cfg_period  in  CNT_W  new period, in base ticks.
cfg_duty  in  CNT_W  new duty (high time), in base ticks.
base_tick  out  1  one-cycle pulse at BASE_TICK_HZ.
ch_tick  out  NUM_CH  one-cycle pulse per channel, at each period wrap.
pwm  out  NUM_CH  registered PWM output per channel.
cfg_pending  out  NUM_CH  shadow holds values not yet applied.

Behaviour:
- Reset (asynchronous, active-high, may assert at any time):
  - prescaler = 0; channel counters = 0.
  - active period = RST_PERIOD; active duty = RST_DUTY.
  - shadow registers cleared; cfg_pending = 0; pwm = 0.
  - base_tick = 0 and ch_tick = 0 while in reset.
- Prescaler:
  - Counts 0..PRESC-1 and wraps to 0.
  - base_tick = (prescaler == PRESC-1), a combinational decode of the register.
  - First base_tick occurs PRESC-1 cycles after reset release.
- Channel counter:
  - Advances only on base_tick while ch_en[i]=1 and active period P != 0.
  - Counts 0..P-1, then wraps to 0.
  - When ch_en[i]=0, the counter is held at 0 on the next clock.
- ch_tick[i] = base_tick & ch_en[i] & (P != 0) & (cnt == P-1).
- pwm[i] register: each cycle loads ch_en[i] & (P != 0) & (cnt < D).
  - pwm lags the counter by one cycle.
  - D = 0 gives constant low.
  - D >= P gives constant high while enabled.
- Config write:
  - On cfg_wr with cfg_ch < NUM_CH: shadow[cfg_ch] <= {cfg_period, cfg_duty} and cfg_pending[cfg_ch] <= 1.
  - cfg_ch >= NUM_CH: write ignored, no state change.
  - A write while pending overwrites the shadow; last write wins.
- Apply shadow to active:
  - Happens in the cycle in which ch_tick[i]=1, or on any cycle where ch_en[i]=0 or active P=0.
  - On apply: counter <= 0 and cfg_pending[i] <= 0.
- cfg_wr in the same cycle as the apply on that channel:
  - The previous shadow content is applied.
  - The new values land in the shadow; cfg_pending stays 1.
- Arithmetic: all compares are unsigned CNT_W bits; no counter overflows, because the counter is bounded by P-1.

Decomposition:
- Shared package holds:
  - the default constants RST_PERIOD, RST_DUTY, BASE_TICK_HZ;
  - a clog2 function for the prescaler width;
  - the channel-configuration struct {period, duty}.
- Natural sub-module: pwm_channel, containing counter, active and shadow registers, pending flag, tick decode and pwm register.
  - Instantiated NUM_CH times via generate.
  - The top level keeps the prescaler and the cfg_ch address decode.

Test Plan:
Bench configuration: CLK_FREQ_HZ=1000, BASE_TICK_HZ=100 (PRESC=10), NUM_CH=2, RST_PERIOD=4, RST_DUTY=1.
1. Release reset, ch_en=01 -> base_tick at cycles 9, 19, 29, ...; ch_tick[0] every 40 cycles, first at cycle 39; pwm[0] high 10 of every 40 cycles; ch 1 outputs stay 0.
2. Mid-period write ch0 {period=2, duty=2} -> cfg_pending[0]=1 the next cycle; old waveform completes; new values apply at the ch_tick; pwm[0] then constant high; ch_tick every 20 cycles; pending clears.
3. Write ch1 {period=3, duty=0} while ch_en[1]=0 -> applied the next cycle, pending never observed high after that cycle; after enabling, ch_tick[1] every 30 cycles and pwm[1] stays 0.
4. cfg_wr with cfg_ch=5 -> no change to any active, shadow or pending state.
5. cfg_wr on ch0 in the exact cycle of its ch_tick -> the prior shadow is applied; the new value is applied at the following wrap; pending stays 1 in between.
6. Assert reset mid-period with pending=1 -> outputs 0 immediately (asynchronous); after release, period=4, duty=1 and pending=0.
